// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Holds the launch FSM state type and the UART data width.
// The GAP state only exists when UART_TXQ_GAP_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
`ifdef UART_TXQ_GAP_EN
        ,
        GAP
`endif
    } txq_state_t;

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO with power-of-two depth, occupancy count and flush.
// Ports: clk, rst (async, active-high), push/pop/flush strobes,
//        din/dout data, level occupancy, full/empty flags.
module uart_txq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    // A full queue refuses pushes even if a pop happens the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter with a launch/handshake FSM.
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready
//        producer side; flush; tx_data/tx_start/tx_busy UART side;
//        level = FIFO occupancy.
// UART_TXQ_GAP_EN adds GAP_CYCLES idle clocks after each byte.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] level
);

    txq_state_t             state;
    logic [UART_DATA_W-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // The head leaves the queue during the single LAUNCH cycle.
    assign pop      = (state == LAUNCH);

    uart_txq_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_data),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

`ifdef UART_TXQ_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // GAP always lasts at least one cycle, so zero behaves like one.
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    logic [GW-1:0] gap_cnt;
`else
    localparam int unused_gap_cycles = GAP_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
`ifdef UART_TXQ_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty && !tx_busy) begin
                        state    <= LAUNCH;
                        tx_start <= 1'b1;
                        tx_data  <= head;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef UART_TXQ_GAP_EN
                        state   <= GAP;
                        gap_cnt <= '0;
`else
                        state   <= IDLE;
`endif
                    end
                end
`ifdef UART_TXQ_GAP_EN
                GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple UART busy model.
// Works with or without UART_TXQ_GAP_EN.
module tb_uart_tx_queue;

    localparam int DEPTH      = 16;
    localparam int GAP_CYCLES = 4;
`ifdef UART_TXQ_GAP_EN
    localparam int GAP_EXP = 2 + GAP_CYCLES;
`else
    localparam int GAP_EXP = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] level;

    logic       force_busy = 1'b0;
    logic       model_busy = 1'b0;
    int         busy_cnt = 0;
    int         cyc = 0;
    logic [7:0] launched[$];
    int         starts[$];
    int         falls[$];
    logic [7:0] expq[$];

    int n_err = 0;
    int n_chk = 0;

    assign tx_busy = force_busy | model_busy;

    always #5 clk = ~clk;

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .level    (level)
    );

    // UART model: busy for 10 cycles after each launch pulse.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_start) begin
            launched.push_back(tx_data);
            starts.push_back(cyc);
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0)
                falls.push_back(cyc);
        end
        model_busy = (busy_cnt != 0);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic clear_log();
        launched.delete();
        starts.delete();
        falls.delete();
    endtask

    initial begin
        logic acc;
        ticks(3);
        chk("rst_level", level, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        ticks(2);

        // single byte latency
        clear_log();
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_level_push", level, 1);
        chk("t1_no_start_yet", tx_start, 0);
        tick();
        chk("t1_start", tx_start, 1);
        chk("t1_data", tx_data, 8'hA5);
        tick();
        chk("t1_start_pulse", tx_start, 0);
        chk("t1_level_pop", level, 0);
        chk("t1_data_hold", tx_data, 8'hA5);
        ticks(25);
        chk("t1_count", launched.size(), 1);

        // fill to full with the UART held busy
        clear_log();
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_level_full", level, 16);
        chk("t2_not_ready", in_ready, 0);
        in_data = 8'h11;
        in_valid = 1'b1;
        ticks(3);
        chk("t2_stall_level", level, 16);
        force_busy = 1'b0;
        acc = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (in_ready) begin
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("t2_accept", acc, 1);
        chk("t2_level_refill", level, 16);
        for (int w = 0; w < 1000 && launched.size() < 17; w++)
            tick();
        chk("t2_count", launched.size(), 17);
        for (int i = 0; i < 17; i++)
            chk($sformatf("t2_order%0d", i), launched[i],
                (i < 16) ? 32'(i + 1) : 32'h11);
        ticks(25);
        chk("t2_level_end", level, 0);

        // three bytes, inter-byte spacing
        clear_log();
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h11 * (i + 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int w = 0; w < 200 && launched.size() < 3; w++)
            tick();
        ticks(25);
        chk("t3_count", launched.size(), 3);
        chk("t3_b0", launched[0], 8'h11);
        chk("t3_b1", launched[1], 8'h22);
        chk("t3_b2", launched[2], 8'h33);
        chk("t3_gap1", starts[1] - falls[0], GAP_EXP);
        chk("t3_gap2", starts[2] - falls[1], GAP_EXP);

        // flush during WAIT_DONE
        clear_log();
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h40 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t4_level_pre", level, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_level_flush", level, 0);
        ticks(40);
        chk("t4_starts", launched.size(), 1);
        chk("t4_frame_done", falls.size(), 1);
        chk("t4_ready", in_ready, 1);

        // reset during WAIT_DONE
        clear_log();
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h70 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t5_level_pre", level, 3);
        rst = 1'b1;
        #1;
        chk("t5_rst_level", level, 0);
        chk("t5_rst_start", tx_start, 0);
        chk("t5_rst_data", tx_data, 8'h00);
        tick();
        rst = 1'b0;
        ticks(30);
        chk("t5_no_launch", launched.size(), 1);
        in_data = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ticks(30);
        chk("t5_new_count", launched.size(), 2);
        chk("t5_new_byte", launched[1], 8'h5A);

        // push and pop together, then wrap-around stream
        clear_log();
        expq.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'hB0 + i);
            expq.push_back(in_data);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t6_level3", level, 3);
        force_busy = 1'b0;
        tick();
        chk("t6_launch", tx_start, 1);
        chk("t6_level_launch", level, 3);
        in_data = 8'hC3;
        expq.push_back(in_data);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6_level_same", level, 3);
        for (int i = 0; i < 40; i++) begin
            in_data = 8'(i * 37 + 5);
            expq.push_back(in_data);
            in_valid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 100; w++) begin
                if (in_ready) begin
                    tick();
                    acc = 1'b1;
                    break;
                end
                tick();
            end
            chk($sformatf("t6_push%0d", i), acc, 1);
        end
        in_valid = 1'b0;
        for (int w = 0; w < 2000 && launched.size() < 44; w++)
            tick();
        chk("t6_count", launched.size(), 44);
        for (int i = 0; i < 44; i++)
            chk($sformatf("t6_order%0d", i), launched[i], expq[i]);
        ticks(25);
        chk("t6_level_end", level, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
